// File: rtl/mips32_dbg_pkg.sv
// Shared definitions for the pipe_MIPS32 debug read-back path.
// - state_e      : register-dump FSM states
// - REG_AW_DEF   : default register index width
// - DW_DEF       : default register data width
// - HALT_OPCODE  : HLT instruction opcode that drives the core HALTED flag
package mips32_dbg_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int DW_DEF     = 32;

  localparam logic [5:0] HALT_OPCODE = 6'h3f;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HALT = 3'd1,
    ST_READ      = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_SEND      = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/mips32_reg_dump.sv
// Register-file dump engine. Once the core reports HALTED, it reads a window
// of registers through the debug read port and streams (index, value) pairs
// over a valid/ready interface.
// Ports:
//   clk1, rst_n           clock / async active-low reset
//   start, abort          1-cycle dump request (samples cfg_*), cancel
//   cfg_first, cfg_count  first index, number of registers (clamped to 2**REG_AW)
//   halted                core HALTED flag (only looked at while waiting)
//   rf_rd_en/addr/data    debug read port, data valid 1 cycle after rf_rd_en
//   m_valid/ready/idx/data/last  output stream
//   busy, done            FSM not idle, 1-cycle completion pulse
module mips32_reg_dump
  import mips32_dbg_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [REG_AW-1:0] cfg_first,
  input  logic [REG_AW:0]   cfg_count,
  input  logic              halted,
  output logic              rf_rd_en,
  output logic [REG_AW-1:0] rf_rd_addr,
  input  logic [DW-1:0]     rf_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [REG_AW-1:0] m_idx,
  output logic [DW-1:0]     m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam logic [REG_AW:0] NREG = REG_AW'(1) << REG_AW;

  state_e              state_q;
  logic [REG_AW-1:0]   ptr_q;
  logic [REG_AW:0]     rem_q;
  logic                rd_en_q, m_valid_q, m_last_q, busy_q, done_q;
  logic [REG_AW-1:0]   rd_addr_q, m_idx_q;
  logic [DW-1:0]       m_data_q;

  logic [REG_AW-1:0]   ptr_d;
  logic [REG_AW:0]     count_d;

  // Index arithmetic wraps naturally at 2**REG_AW. Counts above the register
  // file size are clamped so a dump never revisits a register.
  assign ptr_d   = ptr_q + 1'b1;
  assign count_d = (cfg_count > NREG) ? NREG : cfg_count;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      m_valid_q <= 1'b0;
      m_idx_q   <= '0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        // Abort beats a same-cycle handshake; no done pulse.
        state_q   <= ST_IDLE;
        m_valid_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              ptr_q   <= cfg_first;
              rem_q   <= count_d;
              busy_q  <= 1'b1;
              state_q <= ST_WAIT_HALT;
            end
          end
          ST_WAIT_HALT: begin
            if (halted) begin
              if (rem_q == '0) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= ptr_q;
                state_q   <= ST_READ;
              end
            end
          end
          ST_READ: begin
            state_q <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            m_data_q  <= rf_rd_data;
            m_idx_q   <= ptr_q;
            m_last_q  <= (rem_q == (REG_AW+1)'(1));
            m_valid_q <= 1'b1;
            state_q   <= ST_SEND;
          end
          ST_SEND: begin
            if (m_ready) begin
              m_valid_q <= 1'b0;
              rem_q     <= rem_q - 1'b1;
              ptr_q     <= ptr_d;
              if (rem_q == (REG_AW+1)'(1)) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                // Issue the next read straight away so READ sees rd_en high.
                rd_en_q   <= 1'b1;
                rd_addr_q <= ptr_d;
                state_q   <= ST_READ;
              end
            end
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rf_rd_en   = rd_en_q;
  assign rf_rd_addr = rd_addr_q;
  assign m_valid    = m_valid_q;
  assign m_idx      = m_idx_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mips32_reg_dump.sv
module tb_mips32_reg_dump;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, halted = 1'b0, m_ready = 1'b1;
  logic [4:0]  cfg_first = '0;
  logic [5:0]  cfg_count = '0;
  logic        rf_rd_en, m_valid, m_last, busy, done;
  logic [4:0]  rf_rd_addr, m_idx;
  logic [31:0] rf_rd_data, m_data;

  int checks = 0;
  int fails  = 0;

  always #5 clk1 = ~clk1;

  mips32_reg_dump dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_first(cfg_first), .cfg_count(cfg_count), .halted(halted),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  // Register file after the test program: Rk=k, then R1..R5 overwritten.
  logic [31:0] rf [32];
  initial begin
    for (int k = 0; k < 32; k++) rf[k] = k;
    rf[1] = 32'd10; rf[2] = 32'd20; rf[3] = 32'd25; rf[4] = 32'd30; rf[5] = 32'd55;
  end
  always @(posedge clk1) if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];

  // Hand-computed expected register contents.
  function automatic logic [31:0] rexp(input int k);
    case (k)
      1: return 32'd10;
      2: return 32'd20;
      3: return 32'd25;
      4: return 32'd30;
      5: return 32'd55;
      default: return k;
    endcase
  endfunction

  // Stream monitor
  int          hs_cnt = 0, done_cnt = 0, rd_cnt = 0, vld_cnt = 0, unstable = 0;
  logic [4:0]  h_idx  [256];
  logic [31:0] h_data [256];
  logic        h_last [256];
  logic        stall_pend = 1'b0;
  logic [37:0] stall_snap = '0;

  always @(posedge clk1) begin
    if (!rst_n) begin
      stall_pend <= 1'b0;
    end else begin
      if (m_valid && m_ready && !abort) begin
        h_idx[hs_cnt[7:0]]  <= m_idx;
        h_data[hs_cnt[7:0]] <= m_data;
        h_last[hs_cnt[7:0]] <= m_last;
        hs_cnt <= hs_cnt + 1;
      end
      if (stall_pend && (!m_valid || {m_idx, m_data, m_last} != stall_snap) && !abort)
        unstable <= unstable + 1;
      stall_pend <= m_valid && !m_ready;
      stall_snap <= {m_idx, m_data, m_last};
      if (done)     done_cnt <= done_cnt + 1;
      if (rf_rd_en) rd_cnt   <= rd_cnt + 1;
      if (m_valid)  vld_cnt  <= vld_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [4:0] first, input logic [5:0] count);
    @(negedge clk1);
    cfg_first = first; cfg_count = count; start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
  endtask

  // Wait for done (bounded); optional 1-of-3 ready throttling. Returns at the
  // negedge after the done pulse.
  task automatic wait_done(input bit throttle, output bit ok);
    int cyc = 0;
    ok = 1'b0;
    while (!ok && cyc < 1000) begin
      if (done) ok = 1'b1;
      m_ready = throttle ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk1);
      cyc++;
    end
    m_ready = 1'b1;
  endtask

  task automatic check_words(input string tag, input int base, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      int k = (first + i) % 32;
      chk({tag, "_idx"},  64'(h_idx[(base + i) % 256]),  64'(k));
      chk({tag, "_data"}, 64'(h_data[(base + i) % 256]), 64'(rexp(k)));
      chk({tag, "_last"}, 64'(h_last[(base + i) % 256]), 64'(i == n - 1));
    end
  endtask

  task automatic full_dump(input string tag, input int first, input int count, input int n,
                           input bit throttle);
    int hb, db;
    bit ok;
    hb = hs_cnt; db = done_cnt;
    pulse_start(5'(first), 6'(count));
    wait_done(throttle, ok);
    chk({tag, "_timeout"}, 64'(ok), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_words"}, 64'(hs_cnt - hb), 64'(n));
    chk({tag, "_done_cnt"}, 64'(done_cnt - db), 64'd1);
    check_words(tag, hb, first, n);
  endtask

  initial begin
    int rb, vb, db, hb;
    bit ok;

    // Reset state
    #12;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_rden",  64'(rf_rd_en), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_out",   64'({m_idx, m_data, m_last}), 64'd0);
    @(negedge clk1); rst_n = 1'b1;
    @(negedge clk1);

    // Basic dump with halted already high, ready held
    halted = 1'b1;
    full_dump("basic", 0, 6, 6, 1'b0);

    // Same dump with ready 1-of-3
    rb = unstable;
    full_dump("throttle", 0, 6, 6, 1'b1);
    chk("throttle_stable", 64'(unstable - rb), 64'd0);

    // Index wrap
    full_dump("wrap", 30, 4, 4, 1'b0);

    // Clamp: 40 -> 32 registers
    full_dump("clamp", 0, 40, 32, 1'b0);

    // count=0: done one cycle after halted seen, no reads/valid
    halted = 1'b0;
    rb = rd_cnt; vb = vld_cnt; db = done_cnt;
    pulse_start(5'd0, 6'd0);
    @(negedge clk1);
    halted = 1'b1;
    @(negedge clk1);
    chk("zero_done_lat", 64'(done), 64'd1);
    @(negedge clk1);
    chk("zero_busy_after", 64'(busy), 64'd0);
    chk("zero_reads", 64'(rd_cnt - rb), 64'd0);
    chk("zero_valid", 64'(vld_cnt - vb), 64'd0);
    chk("zero_done_cnt", 64'(done_cnt - db), 64'd1);

    // Wait for halted: 20 idle cycles, then first valid 3 cycles after
    halted = 1'b0;
    rb = rd_cnt; hb = hs_cnt;
    pulse_start(5'd0, 6'd6);
    repeat (20) @(negedge clk1);
    chk("wait_busy", 64'(busy), 64'd1);
    chk("wait_reads", 64'(rd_cnt - rb), 64'd0);
    halted = 1'b1;
    repeat (2) @(negedge clk1);
    chk("wait_lat_early", 64'(m_valid), 64'd0);
    @(negedge clk1);
    chk("wait_lat_valid", 64'(m_valid), 64'd1);
    halted = 1'b0;   // deassert mid-dump: must not matter
    wait_done(1'b0, ok);
    chk("wait_timeout", 64'(ok), 64'd1);
    chk("wait_words", 64'(hs_cnt - hb), 64'd6);
    check_words("wait", hb, 0, 6);
    halted = 1'b1;

    // Reset while idx2 is being offered
    m_ready = 1'b0;
    pulse_start(5'd2, 6'd3);
    repeat (3) @(negedge clk1);
    chk("rst2_valid_pre", 64'(m_valid), 64'd1);
    chk("rst2_idx_pre", 64'(m_idx), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_out", 64'({m_valid, rf_rd_en, busy, done, m_idx, m_data, m_last}), 64'd0);
    @(negedge clk1); rst_n = 1'b1; m_ready = 1'b1;
    full_dump("after_rst", 0, 6, 6, 1'b0);

    // Abort during SEND, same cycle as a handshake
    db = done_cnt; hb = hs_cnt;
    m_ready = 1'b0;
    pulse_start(5'd0, 6'd6);
    repeat (3) @(negedge clk1);
    chk("abort_valid_pre", 64'(m_valid), 64'd1);
    abort = 1'b1; m_ready = 1'b1;
    @(negedge clk1);
    abort = 1'b0;
    chk("abort_valid", 64'(m_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk1);
    chk("abort_no_done", 64'(done_cnt - db), 64'd0);
    chk("abort_no_word", 64'(hs_cnt - hb), 64'd0);

    // start+abort together in IDLE stays idle
    @(negedge clk1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk1);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 64'(busy), 64'd0);

    // start while busy is ignored: second start must not restart the window
    hb = hs_cnt;
    pulse_start(5'd0, 6'd2);
    @(negedge clk1);
    cfg_first = 5'd20; cfg_count = 6'd5; start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    wait_done(1'b0, ok);
    chk("busy_start_timeout", 64'(ok), 64'd1);
    chk("busy_start_words", 64'(hs_cnt - hb), 64'd2);
    check_words("busy_start", hb, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
